// File: rtl/digit_serial_addsub_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// master drives the request side, slave (the datapath) returns status and result.
interface digit_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             carryout;
    logic             overflow;

    modport master (
        output start, sub, X, Y,
        input  busy, done, S, carryout, overflow
    );

    modport slave (
        input  start, sub, X, Y,
        output busy, done, S, carryout, overflow
    );
endinterface

// File: rtl/digit_serial_addsub.sv
// Multi-cycle add/sub: one DIGIT-bit ripple slice per cycle, carry held in a register.
// Latency NDIG+1 edges from accepted start to a one-cycle done pulse.
// No backpressure: start is accepted only while idle, and is dropped (not queued) while busy.
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    digit_serial_addsub_if.slave bus
);
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               co_q, co_d;
    logic               ov_q, ov_d;
    logic               done_q, done_d;

    logic [DIGIT-1:0]       sum_dig;
    logic                   c;
    logic                   c_msb;
    logic                   chain_co;
    logic [WIDTH+DIGIT-1:0] res_cat;

    // c_msb is the carry entering the slice's top bit; on the last slice that is bit WIDTH-1.
    always_comb begin
        c       = carry_q;
        c_msb   = carry_q;
        sum_dig = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) c_msb = c;
            sum_dig[i] = a_q[i] ^ b_q[i] ^ c;
            c          = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        chain_co = c;
    end

    assign res_cat = {sum_dig, res_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        s_d     = s_q;
        co_d    = co_q;
        ov_d    = ov_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.X;
                    b_d     = bus.Y ^ {WIDTH{bus.sub}};
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
                carry_d = chain_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    s_d     = res_cat[WIDTH+DIGIT-1:DIGIT];
                    co_d    = chain_co;
                    ov_d    = c_msb ^ chain_co;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = done_q;
    assign bus.S        = s_q;
    assign bus.carryout = co_q;
    assign bus.overflow = ov_q;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed checks on a 16/4 instance, then a concurrent random sweep over four geometries.
module tb_digit_serial_addsub;
    localparam int NOPS = 1000;
    localparam int CW [4] = '{16, 16, 16, 8};
    localparam int CD [4] = '{1, 4, 16, 2};

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   sweep_go = 1'b0;
    bit [3:0] sweep_done = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    digit_serial_addsub_if #(.WIDTH(16)) mbus ();
    digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mbus)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] x, input logic [15:0] y, input logic s);
        mbus.start = 1'b1;
        mbus.X     = x;
        mbus.Y     = y;
        mbus.sub   = s;
        tick();
        mbus.start = 1'b0;
    endtask

    // edges counts the accepting edge as 1; busy_n counts cycles sampled with busy high.
    task automatic wait_done(output int edges, output int busy_n);
        edges  = 1;
        busy_n = 0;
        while (!mbus.done && edges < 64) begin
            if (mbus.busy) busy_n++;
            tick();
            edges++;
        end
    endtask

    task automatic directed(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic s, input logic [15:0] es, input logic ec, input logic eo);
        int edges, busy_n;
        launch(x, y, s);
        wait_done(edges, busy_n);
        check_eq({tag, "_S"}, mbus.S, es);
        check_eq({tag, "_carry"}, mbus.carryout, ec);
        check_eq({tag, "_ovf"}, mbus.overflow, eo);
        check_eq({tag, "_latency"}, edges, 5);
        check_eq({tag, "_busy_cycles"}, busy_n, 4);
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int W = CW[g];
        localparam int D = CD[g];
        localparam int ND = W / D;
        localparam longint FULL = longint'(1) << W;
        localparam longint HALF = longint'(1) << (W - 1);

        digit_serial_addsub_if #(.WIDTH(W)) sbus ();
        digit_serial_addsub #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (sbus)
        );

        longint x, y, sx, sy, r, u;
        logic   sb, c_exp, o_exp;
        int     edges;
        string  tag;

        initial begin
            sbus.start = 1'b0;
            sbus.sub   = 1'b0;
            sbus.X     = '0;
            sbus.Y     = '0;
            tag = $sformatf("w%0d_d%0d", W, D);
            wait (sweep_go);
            for (int n = 0; n < NOPS; n++) begin
                x  = longint'($urandom) & (FULL - 1);
                y  = longint'($urandom) & (FULL - 1);
                sb = 1'($urandom);
                sbus.start = 1'b1;
                sbus.X     = W'(x);
                sbus.Y     = W'(y);
                sbus.sub   = sb;
                tick();
                edges = 1;
                // Inputs churn while busy, including stray starts that must be ignored.
                while (!sbus.done && edges < 64) begin
                    sbus.X     = W'($urandom);
                    sbus.Y     = W'($urandom);
                    sbus.sub   = 1'($urandom);
                    sbus.start = 1'($urandom);
                    tick();
                    edges++;
                end
                sbus.start = 1'b0;
                sx = (x >= HALF) ? x - FULL : x;
                sy = (y >= HALF) ? y - FULL : y;
                if (sb) begin
                    r     = sx - sy;
                    u     = x - y;
                    c_exp = (x >= y);
                end else begin
                    r     = sx + sy;
                    u     = x + y;
                    c_exp = (u >= FULL);
                end
                o_exp = (r < -HALF) || (r > HALF - 1);
                check_eq({tag, "_S"}, 64'(sbus.S), u & (FULL - 1));
                check_eq({tag, "_carry"}, sbus.carryout, c_exp);
                check_eq({tag, "_ovf"}, sbus.overflow, o_exp);
                check_eq({tag, "_latency"}, edges, ND + 1);
                repeat ($urandom % 3) tick();
            end
            sweep_done[g] = 1'b1;
        end
    end

    initial begin
        int dones;
        logic [15:0] s_seen;
        rst_n      = 1'b0;
        mbus.start = 1'b0;
        mbus.sub   = 1'b0;
        mbus.X     = '0;
        mbus.Y     = '0;
        repeat (2) tick();
        check_eq("rst_busy", mbus.busy, 0);
        check_eq("rst_done", mbus.done, 0);
        check_eq("rst_S", mbus.S, 0);
        check_eq("rst_carry", mbus.carryout, 0);
        check_eq("rst_ovf", mbus.overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        directed("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        directed("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("sub_neg",   16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_ovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Start pulsed on the second busy cycle must not disturb or queue anything.
        launch(16'h1111, 16'h2222, 1'b0);
        tick();
        mbus.start = 1'b1;
        mbus.X     = 16'hAAAA;
        mbus.Y     = 16'h0F0F;
        tick();
        mbus.start = 1'b0;
        dones  = 0;
        s_seen = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (mbus.done) begin
                dones++;
                s_seen = mbus.S;
            end
        end
        check_eq("ignore_done_count", dones, 1);
        check_eq("ignore_S", s_seen, 16'h3333);

        directed("b2b_first", 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0);
        check_eq("b2b_in_done_cycle", mbus.done, 1);
        directed("b2b_second", 16'h0100, 16'h0001, 1'b1, 16'h00FF, 1'b1, 1'b0);

        launch(16'h1234, 16'h1111, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", mbus.busy, 0);
        check_eq("midrst_done", mbus.done, 0);
        check_eq("midrst_S", mbus.S, 0);
        check_eq("midrst_carry", mbus.carryout, 0);
        repeat (2) tick();
        check_eq("midrst_no_done", mbus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        directed("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        sweep_go = 1'b1;
        for (int k = 0; k < 60000 && sweep_done != 4'hF; k++) tick();
        check_eq("sweep_complete", sweep_done, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/digit_serial_addsub.md
# digit_serial_addsub

Parametrised multi-cycle adder/subtractor for the Basys3 lab datapath. It generalises the 4-bit full-adder chain to WIDTH bits. Each cycle it processes one DIGIT-bit slice through a DIGIT-stage ripple chain, with the carry held in a register between slices. A start/busy/done handshake, add/subtract mode and signed-overflow detection trade latency for a short combinational carry path.

## Interface
- WIDTH, 16: operand/result width in bits; WIDTH >= 1.
- DIGIT, 4: bits processed per cycle; 1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0; NDIG = WIDTH/DIGIT.
- clk  input  1  sole clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0: S = X+Y; 1: S = X-Y; sampled with start.
- X  input  WIDTH  operand A; sampled with start.
- Y  input  WIDTH  operand B; sampled with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result valid.
- S  output  WIDTH  result register.
- carryout  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).
- overflow  output  1  two's-complement overflow.

## Operation
- States: IDLE, RUN. Reset enters IDLE. All outputs clear to 0: busy, done, S, carryout, overflow.
- IDLE with start=1 on an edge:
  - Latch X into the A shift register and (Y XOR {WIDTH{sub}}) into the B shift register.
  - Set the carry register to sub and the digit counter to 0.
  - Go to RUN, busy=1.
- IDLE with start=0: hold everything. done drops to 0 one cycle after assertion.
- RUN, each edge:
  - Add the low DIGIT bits of A and B with the carry register through a DIGIT-stage ripple chain.
  - Shift the sum digit into the top of the internal result register, LSB digit first.
  - Shift A and B right by DIGIT, store the chain carry-out, and increment the counter.
- RUN, edge with counter == NDIG-1, in addition to the above:
  - Copy the completed internal result to S.
  - carryout = final chain carry.
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - done=1, busy=0, return to IDLE.
- S, carryout and overflow change only at completion. They hold their last values while busy and after done, until the next completion.
- start while busy=1 is ignored, with no queueing. X, Y and sub may change freely while busy.
- Arithmetic is modulo 2^WIDTH. Subtraction is X + ~Y + 1.
- DIGIT == WIDTH: NDIG=1, a single RUN cycle.
- Reset asserted mid-operation: immediately (asynchronously) return to IDLE, outputs cleared, in-flight operation discarded. No done pulse.

## Timing
- Start accepted at edge t. busy=1 after t. RUN edges are t+1 .. t+NDIG.
- Latency: NDIG+1 edges from accepted start to done.
- After edge t+NDIG: done=1, busy=0 and S valid for exactly one cycle of done.
- Back-to-back operation: start may be high in the done cycle and is accepted at the next edge. Throughput is one operation per NDIG+1 cycles.
- Critical path is DIGIT full-adder stages plus register setup, independent of WIDTH.
- Reset deassertion is synchronised externally. The first valid start is the first edge with rst_n=1.

## Test plan
- WIDTH=16, DIGIT=4, add 0x1234+0x4321 -> S=0x5555, carryout=0, overflow=0; done exactly 5 edges after start; busy high for 4 cycles.
- Add 0x7FFF+0x0001 -> S=0x8000, overflow=1, carryout=0. Add 0xFFFF+0x0001 -> S=0x0000, carryout=1, overflow=0.
- Sub 0x0005-0x0007 -> S=0xFFFE, carryout=0, overflow=0. Sub 0x8000-0x0001 -> S=0x7FFF, overflow=1, carryout=1.
- Pulse start with new operands on the 2nd busy cycle -> ignored; S equals the first operation's result and only one done is seen. Start in the done cycle -> accepted, second done 5 cycles later.
- Assert rst_n=0 on the 2nd RUN cycle -> busy, done and S go to 0 immediately with no clock edge. After release, 0x0001+0x0001 -> S=0x0002.
- Parameter sweep DIGIT=1, 4, 16 at WIDTH=16, plus WIDTH=8/DIGIT=2: 1000 random add/sub operations against a reference model (X±Y, carry, overflow), checking latency NDIG+1 each time.
